// File: rtl/axi4_stream_pkt_fifo_if.sv
// rtl/axi4_stream_pkt_fifo_if.sv - AXI4-Stream signal bundle with master/slave views
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TID_WIDTH   = 1
) ();
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH/8-1:0] tkeep;
    logic [TUSER_WIDTH-1:0]   tuser;
    logic [TDEST_WIDTH-1:0]   tdest;
    logic [TID_WIDTH-1:0]     tid;
    logic                     tlast;
    logic                     tvalid;
    logic                     tready;

    modport master (output tdata, tkeep, tuser, tdest, tid, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tuser, tdest, tid, tlast, tvalid, output tready);
endinterface

// File: rtl/axi4_stream_pkt_fifo.sv
// rtl/axi4_stream_pkt_fifo.sv - single-clock AXI4-Stream packet FIFO, store-and-forward or cut-through
module axi4_stream_pkt_fifo #(
    parameter int TDATA_WIDTH    = 32,
    parameter int TUSER_WIDTH    = 1,
    parameter int TDEST_WIDTH    = 1,
    parameter int TID_WIDTH      = 1,
    parameter int WORDS_AMOUNT   = 16,
    parameter int MODE           = 1,
    parameter int ERR_DROP       = 1,
    parameter int MAX_PKT_WORDS  = WORDS_AMOUNT,
    parameter int DROP_CNT_WIDTH = 16,
    localparam int ADDR_WIDTH    = $clog2(WORDS_AMOUNT)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    output logic                      full_o,
    output logic                      empty_o,
    output logic                      drop_o,
    output logic [DROP_CNT_WIDTH-1:0] drop_cnt_o,
    output logic [ADDR_WIDTH:0]       used_words_o,
    output logic [ADDR_WIDTH:0]       pkts_amount_o,
    axi4_stream_if.slave              pkt_i,
    axi4_stream_if.master             pkt_o
);
    localparam int KEEP_WIDTH = TDATA_WIDTH / 8;
    localparam int WORD_WIDTH = 1 + TUSER_WIDTH + TDEST_WIDTH + TID_WIDTH + KEEP_WIDTH + TDATA_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH   = (ADDR_WIDTH + 1)'(WORDS_AMOUNT);
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH + 1)'(MAX_PKT_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DROP} wr_state_t;

    logic [WORD_WIDTH-1:0] mem [WORDS_AMOUNT];
    wr_state_t             state, state_nxt;
    logic [ADDR_WIDTH:0]   wr_ptr, spec_ptr, rd_ptr, fetch_ptr;
    logic [ADDR_WIDTH:0]   wr_ptr_nxt, spec_ptr_nxt, word_cnt, word_cnt_nxt, fill;
    logic                  beat, err_flag, mem_we, commit_last, drop_evt;
    logic [WORD_WIDTH-1:0] in_word, ram_q, skid0, skid1;
    logic                  fetch, ram_valid, pop, out_last;
    logic [1:0]            skid_cnt, occ;

    assign in_word      = {pkt_i.tlast, pkt_i.tuser, pkt_i.tdest, pkt_i.tid, pkt_i.tkeep, pkt_i.tdata};
    assign fill         = spec_ptr - rd_ptr;
    assign full_o       = (fill == DEPTH);
    assign pkt_i.tready = (MODE == 1) ? 1'b1 : !full_o;
    assign beat         = pkt_i.tvalid && pkt_i.tready;
    assign err_flag     = (ERR_DROP != 0) && pkt_i.tuser[0];
    assign drop_o       = drop_evt;
    assign used_words_o = wr_ptr - rd_ptr;

    // Words are written at spec_ptr; wr_ptr only moves on commit so rollback is a pointer copy.
    always_comb begin
        state_nxt    = state;
        spec_ptr_nxt = spec_ptr;
        wr_ptr_nxt   = wr_ptr;
        word_cnt_nxt = word_cnt;
        mem_we       = 1'b0;
        commit_last  = 1'b0;
        drop_evt     = 1'b0;
        if (MODE == 0) begin
            if (beat) begin
                mem_we       = 1'b1;
                spec_ptr_nxt = spec_ptr + 1'b1;
                wr_ptr_nxt   = spec_ptr + 1'b1;
                commit_last  = pkt_i.tlast;
            end
        end else begin
            unique case (state)
                S_IDLE, S_WRITE: begin
                    if (beat) begin
                        if (word_cnt == MAX_LEN || full_o) begin
                            spec_ptr_nxt = wr_ptr;
                            word_cnt_nxt = '0;
                            if (pkt_i.tlast) begin
                                drop_evt  = 1'b1;
                                state_nxt = S_IDLE;
                            end else begin
                                state_nxt = S_DROP;
                            end
                        end else begin
                            mem_we       = 1'b1;
                            spec_ptr_nxt = spec_ptr + 1'b1;
                            word_cnt_nxt = word_cnt + 1'b1;
                            state_nxt    = S_WRITE;
                            if (pkt_i.tlast) begin
                                word_cnt_nxt = '0;
                                state_nxt    = S_IDLE;
                                if (err_flag) begin
                                    spec_ptr_nxt = wr_ptr;
                                    drop_evt     = 1'b1;
                                end else begin
                                    wr_ptr_nxt  = spec_ptr + 1'b1;
                                    commit_last = 1'b1;
                                end
                            end
                        end
                    end
                end
                S_DROP: begin
                    if (beat && pkt_i.tlast) begin
                        drop_evt  = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            wr_ptr   <= '0;
            spec_ptr <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wr_ptr   <= wr_ptr_nxt;
            spec_ptr <= spec_ptr_nxt;
            word_cnt <= word_cnt_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[spec_ptr[ADDR_WIDTH-1:0]] <= in_word;
        if (fetch)  ram_q <= mem[fetch_ptr[ADDR_WIDTH-1:0]];
    end

    // rd_ptr advances on the output handshake, so words in flight still occupy RAM slots.
    assign pop      = (skid_cnt != 2'd0) && pkt_o.tready;
    assign out_last = skid0[WORD_WIDTH-1];
    assign occ      = skid_cnt + {1'b0, ram_valid} - {1'b0, pop};
    assign fetch    = (wr_ptr != fetch_ptr) && (occ < 2'd2);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fetch_ptr     <= '0;
            rd_ptr        <= '0;
            ram_valid     <= 1'b0;
            skid_cnt      <= '0;
            skid0         <= '0;
            skid1         <= '0;
            pkts_amount_o <= '0;
            drop_cnt_o    <= '0;
        end else begin
            if (fetch) fetch_ptr <= fetch_ptr + 1'b1;
            if (pop)   rd_ptr    <= rd_ptr + 1'b1;
            ram_valid <= fetch;
            skid_cnt  <= occ;
            if (ram_valid && (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && pop))) skid0 <= ram_q;
            else if (pop) skid0 <= skid1;
            if (ram_valid && ((skid_cnt == 2'd1 && !pop) || (skid_cnt == 2'd2 && pop))) skid1 <= ram_q;
            pkts_amount_o <= pkts_amount_o + {{ADDR_WIDTH{1'b0}}, commit_last}
                                           - {{ADDR_WIDTH{1'b0}}, pop && out_last};
            if (drop_evt && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
        end
    end

    assign {pkt_o.tlast, pkt_o.tuser, pkt_o.tdest, pkt_o.tid, pkt_o.tkeep, pkt_o.tdata} = skid0;
    assign pkt_o.tvalid = (skid_cnt != 2'd0);
    assign empty_o      = (skid_cnt == 2'd0);
endmodule
